// File: rtl/uart_receiver.sv
// 8N1 UART receiver: the line is synchronised, a start bit is validated at mid-bit,
// each data bit is sampled at its centre, and the byte is presented with ready/error flags.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic             rx_meta_q, rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]       bit_pos_q, bit_pos_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             rdy_q, rdy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // Both stages reset high so that reset never looks like a start edge.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let both stages sample the old value on the same edge.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_pos_d    = bit_pos_q;
    shift_d      = shift_q;
    data_d       = data_q;
    frame_err_d  = frame_err_q;
    rdy_d        = rdy_q & ~rdy_clr;
    overrun_d    = overrun_q & ~rdy_clr;

    if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d      = START;
            sample_cnt_d = '0;
          end
        end
        START: begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          if (sample_cnt_q == HALF_LAST) begin
            sample_cnt_d = '0;
            bit_pos_d    = '0;
            state_d      = rx_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d       = '0;
            shift_d[bit_pos_q] = rx_s_q;
            if (bit_pos_q == 3'd7) state_d = STOP;
            else                   bit_pos_d = bit_pos_q + 3'd1;
          end
        end
        STOP: begin
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          // Leaving at stop-bit centre keeps half a bit of margin for the next start edge.
          if (sample_cnt_q == FULL_LAST) begin
            sample_cnt_d = '0;
            state_d      = IDLE;
            if (rx_s_q) begin
              data_d      = shift_q;
              rdy_d       = 1'b1;
              frame_err_d = 1'b0;
              overrun_d   = overrun_q | (rdy_q & ~rdy_clr);
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      // NOTE: the shift register is reset with the rest so a mid-frame reset leaves no partial byte.
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_pos_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      rdy_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_pos_q    <= bit_pos_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      rdy_q        <= rdy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out  = data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a frame table plus hand-written sequences for
// glitch, ack-at-completion, line break and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CYC  = OS * TICK_DIV;

  logic       clk_50m = 1'b0;
  logic       rst     = 1'b1;
  logic       rx      = 1'b1;
  logic       clken   = 1'b0;
  logic       rdy_clr = 1'b0;
  logic [7:0] data_out;
  logic       rdy, frame_err, overrun, rx_busy;

  int total = 0;
  int bad   = 0;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .rx       (rx),
    .clken    (clken),
    .rdy_clr  (rdy_clr),
    .data_out (data_out),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  initial forever #10 clk_50m = ~clk_50m;

  // clken is high on every TICK_DIV-th edge; it changes just after posedge.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_50m);
      #1;
      cnt   = (cnt + 1) % TICK_DIV;
      clken = (cnt == 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       clr_before;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_fe;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic r,
                               input logic fe, input logic ov);
    check({tag, "_data"}, data_out, d);
    check({tag, "_rdy"}, {7'd0, rdy}, {7'd0, r});
    check({tag, "_frame_err"}, {7'd0, frame_err}, {7'd0, fe});
    check({tag, "_overrun"}, {7'd0, overrun}, {7'd0, ov});
  endtask

  // A low stop bit is followed by two idle bits so the next start edge is clean.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic clr_before);
    rx = 1'b0;
    if (clr_before) begin
      rdy_clr = 1'b1;
      wait_cycles(1);
      rdy_clr = 1'b0;
      check("clr_rdy", {7'd0, rdy}, 8'd0);
      check("clr_overrun", {7'd0, overrun}, 8'd0);
      wait_cycles(BIT_CYC - 1);
    end else begin
      wait_cycles(BIT_CYC);
    end
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      wait_cycles(BIT_CYC);
    end
    rx = stop;
    wait_cycles(BIT_CYC);
    if (!stop) begin
      rx = 1'b1;
      wait_cycles(2 * BIT_CYC);
    end
  endtask

  // Start detect is tick 0; completion is tick 8 + 8*16 + 16 = 152 later.
  task automatic clr_at_completion();
    int ticks;
    int guard;
    guard = 0;
    while (!rx_busy && guard < 4 * BIT_CYC) begin
      @(negedge clk_50m);
      guard++;
    end
    if (!rx_busy) begin
      total++;
      bad++;
      $display("FAIL busy_rise: got timeout required rx_busy=1");
    end else begin
      ticks = 0;
      while (ticks < OS / 2 + 9 * OS) begin
        @(negedge clk_50m);
        if (clken) ticks++;
      end
      rdy_clr = 1'b1;
      @(negedge clk_50m);
      rdy_clr = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};

    wait_cycles(3);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_busy", {7'd0, rx_busy}, 8'd0);
    rst = 1'b0;
    wait_cycles(2 * BIT_CYC);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].clr_before);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_rdy,
                    vecs[i].exp_fe, vecs[i].exp_ovr);
    end

    rdy_clr = 1'b1;
    wait_cycles(1);
    rdy_clr = 1'b0;
    check_outputs("ack", 8'h22, 1'b0, 1'b0, 1'b0);

    // Four-tick low pulse: start bit rejected at its midpoint.
    rx = 1'b0;
    wait_cycles(3 * TICK_DIV);
    check("glitch_busy_hi", {7'd0, rx_busy}, 8'd1);
    wait_cycles(TICK_DIV);
    rx = 1'b1;
    wait_cycles(BIT_CYC);
    check("glitch_busy_lo", {7'd0, rx_busy}, 8'd0);
    check_outputs("glitch", 8'h22, 1'b0, 1'b0, 1'b0);

    send_frame(8'h77, 1'b1, 1'b0);
    check_outputs("pre_ack", 8'h77, 1'b1, 1'b0, 1'b0);
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      clr_at_completion();
    join
    check_outputs("ack_at_done", 8'h99, 1'b1, 1'b0, 1'b0);

    // Break: first stop sample is low, then START is re-entered while the line stays low.
    rx = 1'b0;
    wait_cycles(625);
    check("break_busy", {7'd0, rx_busy}, 8'd1);
    check_outputs("break_mid", 8'h99, 1'b1, 1'b1, 1'b0);
    wait_cycles(15);
    rx = 1'b1;
    wait_cycles(BIT_CYC);
    check("break_end_busy", {7'd0, rx_busy}, 8'd0);
    check_outputs("break_end", 8'h99, 1'b1, 1'b1, 1'b0);

    // Reset halfway through bit 4 of 0x5A.
    rx = 1'b0;
    wait_cycles(BIT_CYC);
    for (int b = 0; b < 4; b++) begin
      rx = 8'h5A >> b;
      wait_cycles(BIT_CYC);
    end
    rx = 1'b1;
    wait_cycles(BIT_CYC / 2);
    rst = 1'b1;
    wait_cycles(2);
    check("mid_reset_busy", {7'd0, rx_busy}, 8'd0);
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    wait_cycles(2 * BIT_CYC);
    check_outputs("after_abort", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    check_outputs("post_reset", 8'hC3, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
